i2so_sample_fifo: RTL and testbench

//  Stereo sample buffer between the decimation filter output and the I2S output serializer.

---
 rtl/i2so_sample_fifo.sv | 80 ++++++++
 tb/tb_i2so_sample_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/i2so_sample_fifo.sv
// Stereo {left,right} sample FIFO between the decimation filter and the I2S serializer.
// First-word fall-through, rts/rtr handshakes on both sides, saturating underrun counter.
module i2so_sample_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              filt_fifo_rts,
  input  logic [15:0]       filt_fifo_lft,
  input  logic [15:0]       filt_fifo_rgt,
  output logic              fifo_filt_rtr,
  output logic              fifo_i2so_rts,
  output logic [15:0]       fifo_i2so_lft,
  output logic [15:0]       fifo_i2so_rgt,
  input  logic              i2so_fifo_rtr,
  output logic [ADDR_W:0]   fifo_level,
  output logic [7:0]        fifo_underrun
);

  localparam logic [ADDR_W:0] LevelFull = (ADDR_W + 1)'(DEPTH);

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [7:0]        underrun_q, underrun_d;
  logic              push, pop;

  // Handshake outputs come only from the registered level, never from the far side's inputs.
  assign fifo_filt_rtr = (level_q != LevelFull);
  assign fifo_i2so_rts = (level_q != '0);

  assign push = filt_fifo_rts & fifo_filt_rtr;
  assign pop  = fifo_i2so_rts & i2so_fifo_rtr;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    underrun_d = underrun_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    if (i2so_fifo_rtr && !fifo_i2so_rts && underrun_q != 8'hFF) underrun_d = underrun_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage is deliberately not reset; stale words are masked by the empty check below.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {filt_fifo_lft, filt_fifo_rgt};
  end

  always_comb begin
    fifo_i2so_lft = '0;
    fifo_i2so_rgt = '0;
    if (fifo_i2so_rts) begin
      fifo_i2so_lft = mem_q[rd_ptr_q][31:16];
      fifo_i2so_rgt = mem_q[rd_ptr_q][15:0];
    end
  end

  assign fifo_level    = level_q;
  assign fifo_underrun = underrun_q;

endmodule

// File: tb/tb_i2so_sample_fifo.sv
// Directed self-checking bench for i2so_sample_fifo: inputs driven and outputs sampled at negedge.
module tb_i2so_sample_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        filt_fifo_rts;
  logic [15:0] filt_fifo_lft, filt_fifo_rgt;
  logic        fifo_filt_rtr, fifo_i2so_rts;
  logic [15:0] fifo_i2so_lft, fifo_i2so_rgt;
  logic        i2so_fifo_rtr;
  logic [3:0]  fifo_level;
  logic [7:0]  fifo_underrun;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  i2so_sample_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .filt_fifo_rts (filt_fifo_rts),
    .filt_fifo_lft (filt_fifo_lft),
    .filt_fifo_rgt (filt_fifo_rgt),
    .fifo_filt_rtr (fifo_filt_rtr),
    .fifo_i2so_rts (fifo_i2so_rts),
    .fifo_i2so_lft (fifo_i2so_lft),
    .fifo_i2so_rgt (fifo_i2so_rgt),
    .i2so_fifo_rtr (i2so_fifo_rtr),
    .fifo_level    (fifo_level),
    .fifo_underrun (fifo_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One full clock: the posedge acts on current inputs, then return at the next negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] lv [8] = '{16'hFF00, 16'hAAAA, 16'h1111, 16'h3333,
                          16'h5555, 16'h7777, 16'h9999, 16'hBBBB};
  logic [15:0] rv [8] = '{16'h00FF, 16'hCCCC, 16'h2222, 16'h4444,
                          16'h6666, 16'h8888, 16'hAAAA, 16'hDDDD};
  logic [31:0] exp_q [$];
  logic [31:0] head;

  initial begin
    rst_n         = 1'b0;
    filt_fifo_rts = 1'b1;
    filt_fifo_lft = 16'h1234;
    filt_fifo_rgt = 16'h5678;
    i2so_fifo_rtr = 1'b0;

    // T1 reset held for 10 clocks with the filter offering data
    repeat (10) @(negedge clk);
    check("t1_rtr", 32'(fifo_filt_rtr), 32'd1);
    check("t1_rts", 32'(fifo_i2so_rts), 32'd0);
    check("t1_level", 32'(fifo_level), 32'd0);
    check("t1_underrun", 32'(fifo_underrun), 32'd0);
    check("t1_data", {fifo_i2so_lft, fifo_i2so_rgt}, 32'd0);
    filt_fifo_rts = 1'b0;
    rst_n = 1'b1;
    step();
    check("t1_level_after", 32'(fifo_level), 32'd0);

    // T2 fill to full, ignored 9th push, drain in order
    for (int i = 0; i < 8; i++) begin
      filt_fifo_rts = 1'b1;
      filt_fifo_lft = lv[i];
      filt_fifo_rgt = rv[i];
      step();
    end
    check("t2_level_full", 32'(fifo_level), 32'd8);
    check("t2_rtr_full", 32'(fifo_filt_rtr), 32'd0);
    filt_fifo_lft = 16'hDEAD;
    filt_fifo_rgt = 16'hBEEF;
    step();
    filt_fifo_rts = 1'b0;
    check("t2_level_9th", 32'(fifo_level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("t2_rts", 32'(fifo_i2so_rts), 32'd1);
      check("t2_data", {fifo_i2so_lft, fifo_i2so_rgt}, {lv[i], rv[i]});
      i2so_fifo_rtr = 1'b1;
      step();
      i2so_fifo_rtr = 1'b0;
    end
    check("t2_rts_empty", 32'(fifo_i2so_rts), 32'd0);
    check("t2_level_empty", 32'(fifo_level), 32'd0);
    check("t2_underrun", 32'(fifo_underrun), 32'd0);

    // T3 fall-through into an empty FIFO
    filt_fifo_rts = 1'b1;
    filt_fifo_lft = 16'h7398;
    filt_fifo_rgt = 16'hFFDD;
    step();
    filt_fifo_rts = 1'b0;
    check("t3_rts", 32'(fifo_i2so_rts), 32'd1);
    check("t3_data", {fifo_i2so_lft, fifo_i2so_rgt}, 32'h7398FFDD);
    check("t3_level", 32'(fifo_level), 32'd1);
    i2so_fifo_rtr = 1'b1;
    step();
    i2so_fifo_rtr = 1'b0;
    check("t3_rts_after_pop", 32'(fifo_i2so_rts), 32'd0);

    // T4 simultaneous push/pop at level 3 across pointer wraps
    for (int k = 0; k < 3; k++) begin
      filt_fifo_rts = 1'b1;
      filt_fifo_lft = 16'h0100 + 16'(k);
      filt_fifo_rgt = 16'h0200 + 16'(k);
      exp_q.push_back({filt_fifo_lft, filt_fifo_rgt});
      step();
    end
    check("t4_level_start", 32'(fifo_level), 32'd3);
    for (int k = 3; k < 23; k++) begin
      head = exp_q.pop_front();
      check("t4_head", {fifo_i2so_lft, fifo_i2so_rgt}, head);
      filt_fifo_rts = 1'b1;
      filt_fifo_lft = 16'h0100 + 16'(k);
      filt_fifo_rgt = 16'h0200 + 16'(k);
      exp_q.push_back({filt_fifo_lft, filt_fifo_rgt});
      i2so_fifo_rtr = 1'b1;
      step();
      check("t4_level", 32'(fifo_level), 32'd3);
    end
    filt_fifo_rts = 1'b0;
    while (exp_q.size() > 0) begin
      head = exp_q.pop_front();
      check("t4_drain", {fifo_i2so_lft, fifo_i2so_rgt}, head);
      step();
    end
    i2so_fifo_rtr = 1'b0;
    check("t4_empty", 32'(fifo_i2so_rts), 32'd0);
    check("t4_underrun", 32'(fifo_underrun), 32'd0);

    // T5 underrun saturation, then normal delivery
    i2so_fifo_rtr = 1'b1;
    repeat (3) step();
    check("t5_underrun_3", 32'(fifo_underrun), 32'd3);
    repeat (297) step();
    i2so_fifo_rtr = 1'b0;
    check("t5_underrun_sat", 32'(fifo_underrun), 32'hFF);
    check("t5_level", 32'(fifo_level), 32'd0);
    filt_fifo_rts = 1'b1;
    filt_fifo_lft = 16'h5A5A;
    filt_fifo_rgt = 16'hA5A5;
    step();
    filt_fifo_rts = 1'b0;
    check("t5_rts", 32'(fifo_i2so_rts), 32'd1);
    check("t5_data", {fifo_i2so_lft, fifo_i2so_rgt}, 32'h5A5AA5A5);
    i2so_fifo_rtr = 1'b1;
    step();
    i2so_fifo_rtr = 1'b0;
    check("t5_underrun_hold", 32'(fifo_underrun), 32'hFF);

    // T6 asynchronous reset with data in flight
    for (int k = 0; k < 5; k++) begin
      filt_fifo_rts = 1'b1;
      filt_fifo_lft = 16'hC000 + 16'(k);
      filt_fifo_rgt = 16'hD000 + 16'(k);
      step();
    end
    filt_fifo_rts = 1'b0;
    check("t6_level_5", 32'(fifo_level), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("t6_level_rst", 32'(fifo_level), 32'd0);
    check("t6_rts_rst", 32'(fifo_i2so_rts), 32'd0);
    check("t6_underrun_rst", 32'(fifo_underrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    filt_fifo_rts = 1'b1;
    filt_fifo_lft = 16'h1478;
    filt_fifo_rgt = 16'hA3B9;
    step();
    filt_fifo_rts = 1'b0;
    check("t6_level_1", 32'(fifo_level), 32'd1);
    check("t6_data", {fifo_i2so_lft, fifo_i2so_rgt}, 32'h1478A3B9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
